// File: rtl/nn_pkg.sv
// Shared types for the training sequencer: 8.8 fixed-point word, FSM states, run phases.
// No logic of its own; helpers are pure combinational functions.
// Used by train_sequencer and sample_mem.
package nn_pkg;

  localparam int FX_BITS = 16;

  typedef logic [FX_BITS-1:0] fx_t;

  // 1.0 in 8.8 format; labels at or above this count as class 1
  localparam fx_t FX_ONE = 16'h0100;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    NEXT,
    FINISH
  } seq_state_t;

  typedef enum logic {
    TRAIN,
    VAL
  } phase_t;

  // Binary class label of an 8.8 target value
  function automatic logic fx_label(fx_t v);
    return (v >= FX_ONE);
  endfunction

  // Halve a learning rate but never let it reach zero
  function automatic fx_t fx_halve_floor(fx_t v);
    return (v > fx_t'(1)) ? (v >> 1) : fx_t'(1);
  endfunction

endpackage

// File: rtl/sample_mem.sv
// Sample store: DEPTH words of {x, y}, one write port, one registered read port.
// Latency: read data appears the cycle after rd_en_i and then holds until the next rd_en_i.
// Backpressure: none; the caller gates writes (the sequencer drops them while busy).
module sample_mem
  import nn_pkg::*;
#(
  parameter  int DEPTH = 16,
  parameter  int W     = 112,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [W-1:0]  wr_dat_i,
  input  logic          rd_en_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [W-1:0]  rd_dat_o
);

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] rd_dat_q;

  // Array contents survive reset so a loaded dataset outlives an aborted run
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_dat_i;
    end
  end

  // Read register doubles as the x/y output stage, so it is reset to zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_dat_q <= '0;
    end else if (rd_en_i) begin
      rd_dat_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_dat_o = rd_dat_q;

endmodule

// File: rtl/train_sequencer.sv
// Drives TRAIN_EPOCHS training passes (TR) then one validation pass (VL) over the stored samples.
// Latency: start to first TR is 2 cycles; S_Train to next TR/VL is 2 cycles (NEXT, ISSUE).
// Backpressure: waits on S_Train per request; faults after TIMEOUT cycles. LR_DECAY_EN halves lr per epoch.
module train_sequencer
  import nn_pkg::*;
#(
  parameter  int NX           = 6,
  parameter  int BITS         = 16,
  parameter  int DEPTH        = 16,
  parameter  int TRAIN_EPOCHS = 8,
  parameter  int TIMEOUT      = 256,
  localparam int AW           = $clog2(DEPTH),
  localparam int NW           = AW + 1,
  localparam int EW           = $clog2(TRAIN_EPOCHS + 1),
  localparam int WDW          = $clog2(TIMEOUT)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     wr_en,
  input  logic [AW-1:0]            wr_addr,
  input  logic [NX-1:0][BITS-1:0]  wr_x,
  input  logic [BITS-1:0]          wr_y,
  input  logic [NW-1:0]            n_samples,
  input  logic [BITS-1:0]          lr_init,
  output logic                     TR,
  output logic                     VL,
  output logic [NX-1:0][BITS-1:0]  x,
  output logic [BITS-1:0]          lr,
  output logic [BITS-1:0]          y,
  input  logic                     yhat,
  input  logic                     S_Train,
  input  logic                     S_Error,
  output logic                     busy,
  output logic                     done,
  output logic                     fault,
  output logic [EW-1:0]            epoch,
  output logic [15:0]              err_cnt,
  output logic [NW-1:0]            miss_cnt
);

  localparam int               MW      = NX * BITS + BITS;
  localparam logic [NW-1:0]    N_MAX   = NW'(DEPTH);
  localparam logic [WDW-1:0]   WD_LAST = WDW'(TIMEOUT - 1);

  seq_state_t           state_q, state_d;
  phase_t               phase_q, phase_d;
  logic [AW-1:0]        idx_q, idx_d;
  logic [NW-1:0]        n_q, n_d;
  logic [BITS-1:0]      lr_q, lr_d;
  logic [EW-1:0]        epoch_q, epoch_d;
  logic [15:0]          err_q, err_d;
  logic [NW-1:0]        miss_q, miss_d;
  logic                 fault_q, fault_d;
  logic [WDW-1:0]       wd_q, wd_d;
  logic                 prime_q, prime_d;

  logic                 rd_en;
  logic                 tr, vl, fin;
  logic                 busy_w;
  logic                 mem_we;
  logic [MW-1:0]        rd_dat;
  logic [NX-1:0][BITS-1:0] rd_x;
  logic [BITS-1:0]      rd_y;

  assign busy_w = (state_q == ISSUE) || (state_q == WAIT) || (state_q == NEXT);
  // Dataset is frozen for the duration of a run
  assign mem_we = wr_en & ~busy_w;

  sample_mem #(
    .DEPTH (DEPTH),
    .W     (MW)
  ) u_mem (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (mem_we),
    .wr_addr_i (wr_addr),
    .wr_dat_i  ({wr_x, wr_y}),
    .rd_en_i   (rd_en),
    .rd_addr_i (idx_d),
    .rd_dat_o  (rd_dat)
  );

  assign rd_y = rd_dat[BITS-1:0];
  assign rd_x = rd_dat[MW-1:BITS];

  // State and run-context registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      phase_q <= TRAIN;
      idx_q   <= '0;
      n_q     <= '0;
      lr_q    <= '0;
      epoch_q <= '0;
      err_q   <= '0;
      miss_q  <= '0;
      fault_q <= 1'b0;
      wd_q    <= '0;
      prime_q <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      idx_q   <= idx_d;
      n_q     <= n_d;
      lr_q    <= lr_d;
      epoch_q <= epoch_d;
      err_q   <= err_d;
      miss_q  <= miss_d;
      fault_q <= fault_d;
      wd_q    <= wd_d;
      prime_q <= prime_d;
    end
  end

  // Next-state, counters and request strobes
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    idx_d   = idx_q;
    n_d     = n_q;
    lr_d    = lr_q;
    epoch_d = epoch_q;
    err_d   = err_q;
    miss_d  = miss_q;
    fault_d = fault_q;
    wd_d    = wd_q;
    prime_d = prime_q;
    rd_en   = 1'b0;
    tr      = 1'b0;
    vl      = 1'b0;
    fin     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (n_samples == '0) begin
            state_d = FINISH;
          end else begin
            n_d     = (n_samples > N_MAX) ? N_MAX : n_samples;
            lr_d    = lr_init;
            fault_d = 1'b0;
            epoch_d = '0;
            err_d   = '0;
            miss_d  = '0;
            idx_d   = '0;
            phase_d = TRAIN;
            // First ISSUE after start spends a cycle fetching sample 0
            prime_d = 1'b1;
            state_d = ISSUE;
          end
        end
      end

      ISSUE: begin
        if (prime_q) begin
          rd_en   = 1'b1;
          prime_d = 1'b0;
        end else begin
          tr      = (phase_q == TRAIN);
          vl      = (phase_q == VAL);
          wd_d    = '0;
          state_d = WAIT;
        end
      end

      WAIT: begin
        if (S_Train) begin
          if (phase_q == TRAIN) begin
            if (S_Error && (err_q != 16'hFFFF)) begin
              err_d = err_q + 16'd1;
            end
          end else if (yhat != fx_label(fx_t'(rd_y))) begin
            miss_d = miss_q + NW'(1);
          end
          state_d = NEXT;
        end else if (wd_q == WD_LAST) begin
          fault_d = 1'b1;
          state_d = FINISH;
        end else begin
          wd_d = wd_q + WDW'(1);
        end
      end

      NEXT: begin
        if (({1'b0, idx_q} + NW'(1)) < n_q) begin
          idx_d   = idx_q + AW'(1);
          rd_en   = 1'b1;
          state_d = ISSUE;
        end else if (phase_q == TRAIN) begin
          idx_d   = '0;
          rd_en   = 1'b1;
          epoch_d = epoch_q + EW'(1);
          if (epoch_d == EW'(TRAIN_EPOCHS)) begin
            phase_d = VAL;
          end
`ifdef LR_DECAY_EN
          lr_d = BITS'(fx_halve_floor(fx_t'(lr_q)));
`else
          lr_d = lr_q;
`endif
          state_d = ISSUE;
        end else begin
          state_d = FINISH;
        end
      end

      FINISH: begin
        fin     = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign TR       = tr;
  assign VL       = vl;
  assign done     = fin;
  assign busy     = busy_w;
  assign x        = rd_x;
  assign y        = rd_y;
  assign lr       = lr_q;
  assign fault    = fault_q;
  assign epoch    = epoch_q;
  assign err_cnt  = err_q;
  assign miss_cnt = miss_q;

endmodule

// File: tb/tb_train_sequencer.sv
// Directed bench for train_sequencer with a fixed-delay Architecture responder.
// Checks pulse counts, latencies, counters, timeout fault, async abort, clamp and lr schedule.
// Responder acks each TR/VL five cycles after the pulse unless disabled.
module tb_train_sequencer;

  localparam int NX    = 6;
  localparam int BITS  = 16;
  localparam int DEPTH = 16;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b1;
  logic                    start = 1'b0;
  logic                    wr_en = 1'b0;
  logic [3:0]              wr_addr = '0;
  logic [NX-1:0][BITS-1:0] wr_x = '0;
  logic [15:0]             wr_y = '0;
  logic [4:0]              n_samples = '0;
  logic [15:0]             lr_init = '0;
  logic                    TR, VL;
  logic [NX-1:0][BITS-1:0] x;
  logic [15:0]             lr, y;
  logic                    yhat = 1'b0;
  logic                    S_Train = 1'b0;
  logic                    S_Error = 1'b0;
  logic                    busy, done, fault;
  logic [3:0]              epoch;
  logic [15:0]             err_cnt;
  logic [4:0]              miss_cnt;

  train_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_x(wr_x), .wr_y(wr_y), .n_samples(n_samples), .lr_init(lr_init),
    .TR(TR), .VL(VL), .x(x), .lr(lr), .y(y), .yhat(yhat), .S_Train(S_Train),
    .S_Error(S_Error), .busy(busy), .done(done), .fault(fault), .epoch(epoch),
    .err_cnt(err_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_fail = 0;

  // sample table and bench-side labels
  logic [NX-1:0][15:0] samp_x [DEPTH];
  logic [15:0]         samp_y [DEPTH];

  // monitor state
  int                  tr_pulses, vl_pulses, done_pulses, both_cnt;
  int                  first_tr_cyc, second_tr_cyc, done_cyc, start_cyc;
  logic [NX-1:0][15:0] x_first;
  logic [15:0]         y_first_vl;
  logic [15:0]         lr_seen [8];

  // responder state
  int   rcnt = 0;
  int   resp_tr, resp_vl;
  logic pend_err = 1'b0, pend_yhat = 1'b0;
  logic resp_en = 1'b1, err_mode = 1'b0, yhat_one = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (TR) begin
        tr_pulses++;
        if (tr_pulses == 1) begin first_tr_cyc = cyc; x_first = x; end
        if (tr_pulses == 2) second_tr_cyc = cyc;
        if (((tr_pulses - 1) % 2 == 0) && ((tr_pulses - 1) / 2 < 8)) lr_seen[(tr_pulses - 1) / 2] = lr;
      end
      if (VL) begin
        vl_pulses++;
        if (vl_pulses == 1) y_first_vl = y;
      end
      if (TR && VL) both_cnt++;
      if (done) begin done_pulses++; done_cyc = cyc; end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      S_Train = 1'b0;
      S_Error = 1'b0;
      yhat    = 1'b0;
      if (!rst_n) begin
        rcnt = 0;
      end else begin
        if (rcnt > 0) begin
          rcnt--;
          if (rcnt == 0) begin
            S_Train = 1'b1;
            S_Error = pend_err;
            yhat    = pend_yhat;
          end
        end
        if (resp_en && (TR || VL)) begin
          rcnt = 5;
          if (TR) begin
            resp_tr++;
            pend_err  = err_mode && (resp_tr % 3 == 0);
            pend_yhat = 1'b0;
          end else begin
            // S_Error during validation must not be counted
            pend_err  = err_mode;
            pend_yhat = yhat_one ? 1'b1 : ((resp_vl < DEPTH) && (samp_y[resp_vl] >= 16'h0100));
            resp_vl++;
          end
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    tr_pulses = 0; vl_pulses = 0; done_pulses = 0;
    first_tr_cyc = -1; second_tr_cyc = -1; done_cyc = -1;
    resp_tr = 0; resp_vl = 0;
    for (int i = 0; i < 8; i++) lr_seen[i] = '0;
  endtask

  task automatic do_start(input logic [4:0] n, input logic [15:0] lr0);
    tick();
    n_samples = n;
    lr_init   = lr0;
    start     = 1'b1;
    start_cyc = cyc;
    tick();
    start     = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int k;
    k = 0;
    while (done_pulses == 0 && k < budget) begin tick(); k++; end
    check({tag, "_done_seen"}, (done_pulses != 0), 1);
    repeat (4) tick();
  endtask

  task automatic wait_tr(input int budget, input string tag);
    int k;
    k = 0;
    while (tr_pulses == 0 && k < budget) begin tick(); k++; end
    check({tag, "_tr_seen"}, (tr_pulses != 0), 1);
  endtask

  logic [NX-1:0][15:0] x_one;
  logic [15:0]         lr_exp [8];
  logic [15:0]         lr_end_exp;

  initial begin
    both_cnt = 0;
    clear_mon();
    for (int l = 0; l < NX; l++) x_one[l] = 16'h0100;
    for (int i = 0; i < DEPTH; i++) begin
      for (int l = 0; l < NX; l++) samp_x[i][l] = 16'(i * 16 + l + 1);
      samp_y[i] = (i % 3 == 0) ? 16'h0100 : 16'h00FF;
    end
    samp_x[0] = x_one; samp_y[0] = 16'h0100;
    samp_x[1] = x_one; samp_y[1] = 16'h0000;
`ifdef LR_DECAY_EN
    lr_exp[0] = 16'h10; lr_exp[1] = 16'h08; lr_exp[2] = 16'h04; lr_exp[3] = 16'h02;
    for (int i = 4; i < 8; i++) lr_exp[i] = 16'h01;
    lr_end_exp = 16'h0001;
`else
    for (int i = 0; i < 8; i++) lr_exp[i] = 16'h10;
    lr_end_exp = 16'h0002;
`endif

    // reset state
    #3 rst_n = 1'b0;
    repeat (3) tick();
    check("rst_TR", TR, 0);
    check("rst_VL", VL, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_fault", fault, 0);
    check("rst_x", x, 0);
    check("rst_y", y, 0);
    check("rst_lr", lr, 0);
    check("rst_epoch", epoch, 0);
    check("rst_err", err_cnt, 0);
    check("rst_miss", miss_cnt, 0);
    rst_n = 1'b1;

    // load the whole dataset
    for (int i = 0; i < DEPTH; i++) begin
      tick();
      wr_en = 1'b1; wr_addr = 4'(i); wr_x = samp_x[i]; wr_y = samp_y[i];
    end
    tick();
    wr_en = 1'b0;

    // run A: yhat always 1, S_Error every third TR
    clear_mon(); yhat_one = 1'b1; err_mode = 1'b1;
    do_start(5'd2, 16'h0002);
    wait_done(1000, "A");
    check("A_tr_pulses", tr_pulses, 16);
    check("A_vl_pulses", vl_pulses, 2);
    check("A_epoch", epoch, 8);
    check("A_done_once", done_pulses, 1);
    check("A_busy_after", busy, 0);
    check("A_miss", miss_cnt, 1);
    check("A_err", err_cnt, 5);
    check("A_fault", fault, 0);
    check("A_start_lat", first_tr_cyc - start_cyc, 2);
    check("A_ack_to_tr", second_tr_cyc - first_tr_cyc, 7);
    check("A_x_first", x_first, x_one);
    check("A_y_first_vl", y_first_vl, 16'h0100);
    check("A_lr_end", lr, lr_end_exp);

    // run B: matching yhat, no errors; start and write while busy must be ignored
    clear_mon(); yhat_one = 1'b0; err_mode = 1'b0;
    do_start(5'd2, 16'h0002);
    wait_tr(20, "B");
    check("B_busy_mid", busy, 1);
    wr_en = 1'b1; wr_addr = 4'd0; wr_x = '0; wr_y = 16'h0000;
    n_samples = 5'd1; start = 1'b1;
    tick();
    wr_en = 1'b0; start = 1'b0;
    wait_done(1000, "B");
    check("B_tr_pulses", tr_pulses, 16);
    check("B_vl_pulses", vl_pulses, 2);
    check("B_miss", miss_cnt, 0);
    check("B_err", err_cnt, 0);
    check("B_done_once", done_pulses, 1);

    // zero-sample start: done next cycle, no requests
    clear_mon();
    tick();
    n_samples = 5'd0; start = 1'b1;
    tick();
    start = 1'b0;
    check("Z_done_next", done, 1);
    check("Z_busy", busy, 0);
    tick();
    check("Z_done_drop", done, 0);
    check("Z_no_tr", tr_pulses + vl_pulses, 0);

    // asynchronous abort two cycles into WAIT
    clear_mon();
    do_start(5'd2, 16'h0002);
    wait_tr(20, "R");
    tick(); tick();
    check("R_busy_before", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("R_busy", busy, 0);
    check("R_TR", TR, 0);
    check("R_x", x, 0);
    check("R_y", y, 0);
    check("R_lr", lr, 0);
    tick(); tick();
    check("R_no_done", done_pulses, 0);
    rst_n = 1'b1;
    clear_mon();
    do_start(5'd2, 16'h0002);
    wait_done(1000, "R2");
    check("R2_tr_pulses", tr_pulses, 16);
    check("R2_vl_pulses", vl_pulses, 2);
    check("R2_epoch", epoch, 8);
    check("R2_x_first", x_first, x_one);
    check("R2_miss", miss_cnt, 0);

    // timeout: no acknowledge at all
    clear_mon(); resp_en = 1'b0;
    do_start(5'd2, 16'h0002);
    wait_done(600, "T");
    check("T_fault", fault, 1);
    check("T_tr_pulses", tr_pulses, 1);
    check("T_vl_pulses", vl_pulses, 0);
    check("T_done_lat", done_cyc - first_tr_cyc, 257);
    check("T_done_once", done_pulses, 1);
    check("T_busy_after", busy, 0);
    resp_en = 1'b1;
    clear_mon();
    do_start(5'd2, 16'h0002);
    check("T2_fault_clr", fault, 0);
    wait_done(1000, "T2");
    check("T2_fault", fault, 0);
    check("T2_tr_pulses", tr_pulses, 16);

    // n_samples above DEPTH clamps to DEPTH
    clear_mon();
    do_start(5'd20, 16'h0002);
    wait_done(3000, "C");
    check("C_tr_pulses", tr_pulses, 128);
    check("C_vl_pulses", vl_pulses, 16);
    check("C_miss", miss_cnt, 0);
    check("C_epoch", epoch, 8);

    // learning-rate schedule across epochs
    clear_mon();
    do_start(5'd2, 16'h0010);
    wait_done(1000, "L");
    for (int i = 0; i < 8; i++) check($sformatf("L_lr_epoch%0d", i), lr_seen[i], lr_exp[i]);

    check("TR_VL_overlap", both_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
